// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial LSB-first two's-complement adder/subtractor.
//               Uses one full adder/subtractor cell with a start/done handshake.
//               An optional carry/borrow-in port is enabled by SERIAL_ADDSUB_CIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_ns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_CIN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             mode;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic             accept;
    logic             last_bit;
    logic             x;
    logic             y;
    logic             s;
    logic             carry_nxt;
    logic             ovf_nxt;

    assign accept   = start && (state != S_RUN);
    assign last_bit = (state == S_RUN) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single adder/subtractor cell; in subtract mode carry is the borrow of x-y-c
    always_comb begin
        x         = a_sr[0];
        y         = b_sr[0];
        s         = x ^ y ^ carry;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        if (mode) begin
            carry_nxt = (x & y) | (x & carry) | (y & carry);
            ovf_nxt   = (a_msb == b_msb) && (s != a_msb);
        end else begin
            carry_nxt = (~x & y) | (~x & carry) | (y & carry);
            ovf_nxt   = (a_msb != b_msb) && (s != a_msb);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            mode   <= 1'b0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            cnt   <= '0;
            mode  <= a_ns;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cout  <= 1'b0;
            ovf   <= 1'b0;
`ifdef SERIAL_ADDSUB_CIN_EN
            carry <= cin;
`else
            carry <= 1'b0;
`endif
        end else if (state == S_RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            result <= {s, result[WIDTH-1:1]};
            carry  <= carry_nxt;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                cout <= carry_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// Directed, table-driven bench for serial_addsub (WIDTH=8).
module tb_serial_addsub;

    localparam int WIDTH = 8;

    typedef struct {
        string      name;
        logic       mode;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic [7:0] exp_res;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a_ns  = 1'b0;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;
`ifdef SERIAL_ADDSUB_CIN_EN
    logic       cin   = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_ns   (a_ns),
        .a      (a),
        .b      (b),
`ifdef SERIAL_ADDSUB_CIN_EN
        .cin    (cin),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present an operation before the next edge; returns #1 after that edge
    task automatic accept(input logic m, input logic [7:0] x, input logic [7:0] y, input logic ci);
        @(negedge clk);
        a_ns  = m;
        a     = x;
        b     = y;
`ifdef SERIAL_ADDSUB_CIN_EN
        cin   = ci;
`else
        if (ci) $display("note: cin ignored without SERIAL_ADDSUB_CIN_EN");
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    vec_t vecs[$];
    int   lat;
    int   lat2;

    initial begin
        vecs.push_back('{"add_35_4a", 1'b1, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0});
        vecs.push_back('{"add_ff_01", 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{"add_7f_01", 1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"sub_50_30", 1'b0, 8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0});
        vecs.push_back('{"sub_30_50", 1'b0, 8'h30, 8'h50, 1'b0, 8'hE0, 1'b1, 1'b0});
        vecs.push_back('{"sub_80_01", 1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1});
        vecs.push_back('{"add_80_80", 1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
`ifdef SERIAL_ADDSUB_CIN_EN
        vecs.push_back('{"cin_add_01_01", 1'b1, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0});
        vecs.push_back('{"cin_sub_05_02", 1'b0, 8'h05, 8'h02, 1'b1, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{"cin_sub_00_00", 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            accept(vecs[i].mode, vecs[i].av, vecs[i].bv, vecs[i].ci);
            check({vecs[i].name, "_busy_at_accept"}, busy, 1);
            check({vecs[i].name, "_cout_cleared"}, cout, 0);
            check({vecs[i].name, "_ovf_cleared"}, ovf, 0);
            wait_done(lat);
            check({vecs[i].name, "_latency"}, lat, WIDTH);
            check({vecs[i].name, "_busy_with_done"}, busy, 0);
            check({vecs[i].name, "_result"}, result, vecs[i].exp_res);
            check({vecs[i].name, "_cout"}, cout, vecs[i].exp_cout);
            check({vecs[i].name, "_ovf"}, ovf, vecs[i].exp_ovf);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_done_width"}, done, 0);
            check({vecs[i].name, "_result_hold"}, result, vecs[i].exp_res);
        end

        // start and operand changes mid-RUN must not disturb the operation
        accept(1'b1, 8'h35, 8'h4A, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        a_ns  = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat2);
        check("midrun_latency", lat2 + 4, WIDTH);
        check("midrun_result", result, 8'h7F);
        check("midrun_cout", cout, 0);

        // Back-to-back: start during the DONE cycle
        @(posedge clk);
        #1;
        accept(1'b0, 8'h50, 8'h30, 1'b0);
        wait_done(lat);
        check("b2b_first_result", result, 8'h20);
        a_ns  = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
`ifdef SERIAL_ADDSUB_CIN_EN
        cin   = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accepted", busy, 1);
        check("b2b_done_dropped", done, 0);
        wait_done(lat);
        check("b2b_done_spacing", lat + 1, WIDTH + 1);
        check("b2b_second_result", result, 8'h00);
        check("b2b_second_cout", cout, 1);
        @(posedge clk);
        #1;

        // Reset in cycle 4 of RUN aborts the operation
        accept(1'b1, 8'h7F, 8'h7F, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_done", done, 0);
        accept(1'b1, 8'h01, 8'h02, 1'b0);
        wait_done(lat);
        check("post_abort_latency", lat, WIDTH);
        check("post_abort_result", result, 8'h03);
        check("post_abort_cout", cout, 0);
        @(posedge clk);
        #1;

        check("busy_done_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial two's-complement adder/subtractor that processes a WIDTH-bit operand pair LSB-first, one bit per clock, through a single full-adder/subtractor cell and a carry/borrow flip-flop. A start/done handshake makes it a drop-in sequential arithmetic unit for the datapath. It trades gate count for latency against the combinational ripple chain. The 1-bit cell follows the team's full adder/subtractor truth table, including the a_ns polarity.

## Interface
- WIDTH, default 8: operand/result width in bits, ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- a_ns  in  1  1 = add (a+b), 0 = subtract (a−b); latched on accept.
- a  in  WIDTH  operand A; latched on accept.
- b  in  WIDTH  operand B; latched on accept.
- cin  in  1  initial carry/borrow-in; present only with SERIAL_ADDSUB_CIN_EN.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result/cout/ovf valid.
- result  out  WIDTH  sum or difference.
- cout  out  1  add: carry-out; subtract: borrow-out.
- ovf  out  1  signed overflow.
- Reset behaviour: one clock, single active-low synchronous reset; no asynchronous path.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, busy=0, done=0, result=0, cout=0, ovf=0, bit counter=0, carry FF=0.
- IDLE/DONE with start=1:
  - latch a, b, a_ns into shift registers;
  - load carry FF with 0, or with cin under the macro;
  - counter=0;
  - go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each cycle, with x=A[0], y=B[0], c=carry FF:
  - s = x^y^c in both modes.
  - Add: carry' = xy | xc | yc.
  - Subtract: carry' = (~x&y) | (~x&c) | (y&c), i.e. borrow of x−y−c.
  - Shift A and B right by one.
  - Shift result right with s entering the MSB.
  - Increment the counter.
- After the bit with counter=WIDTH−1 is registered:
  - cout = final carry FF;
  - ovf from operand MSBs a_m, b_m and result MSB r_m;
  - add: ovf = (a_m==b_m) & (r_m!=a_m);
  - subtract: ovf = (a_m!=b_m) & (r_m!=a_m);
  - go to DONE.
- start while RUN: ignored; no queuing.
- Input changes during RUN have no effect.
- result, cout and ovf hold their values until the next accept.
- At accept, cout and ovf clear to 0. result then shifts, and its intermediate values are not valid.
- rst_n=0 in any state, including mid-RUN: abort and return to the reset values on that edge.
- Arithmetic is modulo 2^WIDTH; cout/ovf carry the extra information.

## Timing
- Accept edge E0: busy=1 from E0 until edge E_WIDTH.
- Bit i is registered at edge E(i+1).
- At E_WIDTH: result, cout and ovf are final; busy=0; done=1.
- done drops at E_WIDTH+1.
- Latency start-accept to done: exactly WIDTH cycles.
- Back-to-back: start=1 during the DONE cycle is accepted at E_WIDTH+1. Throughput is WIDTH+1 cycles per operation.
- done and busy are never 1 together.

## Configuration
- SERIAL_ADDSUB_CIN_EN defined:
  - cin port exists and is latched into the carry FF on accept.
  - Enables multiword chaining; cout of the low word feeds cin of the high word, for both add and subtract.
- Not defined:
  - no cin port;
  - carry FF loads 0 on accept.

## Test plan
- WIDTH=8, add 0x35+0x4A -> result=0x7F, cout=0, ovf=0; done exactly 8 cycles after accept, 1 cycle wide; busy=0 with done.
- Add 0xFF+0x01 -> 0x00, cout=1, ovf=0. Add 0x7F+0x01 -> 0x80, cout=0, ovf=1.
- Subtract:
  - 0x50−0x30 -> 0x20, cout=0, ovf=0;
  - 0x30−0x50 -> 0xE0, cout=1, ovf=0;
  - 0x80−0x01 -> 0x7F, cout=0, ovf=1.
- Re-assert start with new operands mid-RUN -> ignored, original result delivered. Start during the DONE cycle -> accepted, second done 9 cycles after the first.
- rst_n=0 at cycle 4 of RUN -> next edge: busy=0, done=0, result=0, cout=0, ovf=0, state IDLE. A following add 0x01+0x02 -> 0x03.
- With SERIAL_ADDSUB_CIN_EN:
  - cin=1, add 0x01+0x01 -> 0x03;
  - cin=1, subtract 0x05−0x02 -> 0x02, cout=0;
  - cin=1, subtract 0x00−0x00 -> 0xFF, cout=1.
